// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader
//   Parses a byte stream of load packets and produces write strobes for the
//   8-bit sprite image-index RAM and the 24-bit palette RAM.
//   Packet: A5, TYPE (01 palette / 02 image), ADDR_HI, ADDR_LO, CNT_HI,
//   CNT_LO, payload (N bytes for image, 3*N bytes R,G,B for palette).
//
// Ports
//   pixel_clk_in   clock, rising edge
//   rst_in         synchronous active-high reset
//   byte_in        stream byte
//   byte_valid_in  byte_in valid this cycle (no backpressure)
//   img_we_out     image RAM write strobe
//   img_addr_out   image RAM write address
//   img_data_out   image RAM write data
//   pal_we_out     palette RAM write strobe
//   pal_addr_out   palette RAM write address
//   pal_data_out   palette RAM write data {R,G,B}
//   busy_out       high while a packet is being parsed
//   done_out       one-cycle pulse, packet completed
//   error_out      one-cycle pulse, packet aborted
//
// State table
//   S_IDLE    | hunting for the A5 sync byte
//   S_TYPE    | expecting packet type
//   S_ADDR_HI | expecting start address high byte
//   S_ADDR_LO | expecting start address low byte, range check
//   S_CNT_HI  | expecting entry count high byte
//   S_CNT_LO  | expecting entry count low byte, N=0 finishes here
//   S_PAYLOAD | consuming payload bytes, issuing writes

module sprite_ram_loader #(
  parameter int IMG_DEPTH      = 4096,
  parameter int PAL_DEPTH      = 256,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         pixel_clk_in,
  input  logic                         rst_in,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid_in,
  output logic                         img_we_out,
  output logic [$clog2(IMG_DEPTH)-1:0] img_addr_out,
  output logic [7:0]                   img_data_out,
  output logic                         pal_we_out,
  output logic [$clog2(PAL_DEPTH)-1:0] pal_addr_out,
  output logic [23:0]                  pal_data_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         error_out
);

  localparam int IAW = $clog2(IMG_DEPTH);
  localparam int PAW = $clog2(PAL_DEPTH);
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   IMG_LIM  = 17'(IMG_DEPTH);
  localparam logic [16:0]   PAL_LIM  = 17'(PAL_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO, S_PAYLOAD
  } state_t;

  state_t state, state_next;

  logic          is_pal;
  logic [7:0]    addr_hi;
  logic [7:0]    cnt_hi;
  logic [15:0]   cur_addr;
  logic [15:0]   remaining;
  logic [1:0]    phase;
  logic [15:0]   rg;
  logic [TW-1:0] tmo_cnt;

  logic [15:0] start_addr;
  logic [15:0] count_val;
  logic        addr_ok;
  logic        timeout;
  logic        unit_done;
  logic        last_unit;

  logic img_we_d, pal_we_d, done_d, error_d;

  assign start_addr = {addr_hi, byte_in};
  assign count_val  = {cnt_hi, byte_in};
  assign addr_ok    = is_pal ? ({1'b0, start_addr} < PAL_LIM)
                             : ({1'b0, start_addr} < IMG_LIM);
  // Timeout only fires on a cycle without a byte, so it can never collide
  // with a byte-driven done or error.
  assign timeout    = (state != S_IDLE) && !byte_valid_in && (tmo_cnt == '0);
  // A payload byte completes an entry: every byte for image, every B for palette.
  assign unit_done  = byte_valid_in && (state == S_PAYLOAD) &&
                      (!is_pal || (phase == 2'd2));
  assign last_unit  = (remaining == 16'd1);

  // State register
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = S_IDLE;
    end else if (byte_valid_in) begin
      case (state)
        S_IDLE:    if (byte_in == 8'hA5) state_next = S_TYPE;
        S_TYPE:    state_next = (byte_in == 8'h01 || byte_in == 8'h02) ? S_ADDR_HI : S_IDLE;
        S_ADDR_HI: state_next = S_ADDR_LO;
        S_ADDR_LO: state_next = addr_ok ? S_CNT_HI : S_IDLE;
        S_CNT_HI:  state_next = S_CNT_LO;
        S_CNT_LO:  state_next = (count_val == 16'd0) ? S_IDLE : S_PAYLOAD;
        S_PAYLOAD: if (unit_done && last_unit) state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Output decode: values the output registers take on the next edge
  always_comb begin
    img_we_d = unit_done && !is_pal;
    pal_we_d = unit_done && is_pal;
    done_d   = (unit_done && last_unit) ||
               (byte_valid_in && (state == S_CNT_LO) && (count_val == 16'd0));
    error_d  = timeout ||
               (byte_valid_in && (state == S_TYPE) &&
                (byte_in != 8'h01) && (byte_in != 8'h02)) ||
               (byte_valid_in && (state == S_ADDR_LO) && !addr_ok);
  end

  assign busy_out = (state != S_IDLE);

  // Datapath and registered outputs
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      img_we_out   <= 1'b0;
      img_addr_out <= '0;
      img_data_out <= '0;
      pal_we_out   <= 1'b0;
      pal_addr_out <= '0;
      pal_data_out <= '0;
      done_out     <= 1'b0;
      error_out    <= 1'b0;
      is_pal       <= 1'b0;
      addr_hi      <= '0;
      cnt_hi       <= '0;
      cur_addr     <= '0;
      remaining    <= '0;
      phase        <= '0;
      rg           <= '0;
      tmo_cnt      <= TMO_LOAD;
    end else begin
      img_we_out <= img_we_d;
      pal_we_out <= pal_we_d;
      done_out   <= done_d;
      error_out  <= error_d;

      if (img_we_d) begin
        img_addr_out <= cur_addr[IAW-1:0];
        img_data_out <= byte_in;
      end
      if (pal_we_d) begin
        pal_addr_out <= cur_addr[PAW-1:0];
        pal_data_out <= {rg, byte_in};
      end

      if ((state == S_IDLE) || byte_valid_in) tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0)                 tmo_cnt <= tmo_cnt - 1'b1;

      if (byte_valid_in) begin
        case (state)
          S_TYPE:    is_pal   <= (byte_in == 8'h01);
          S_ADDR_HI: addr_hi  <= byte_in;
          S_ADDR_LO: cur_addr <= start_addr;
          S_CNT_HI:  cnt_hi   <= byte_in;
          S_CNT_LO: begin
            remaining <= count_val;
            phase     <= 2'd0;  // a new packet never inherits a partial triple
          end
          S_PAYLOAD: begin
            rg    <= {rg[7:0], byte_in};
            phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            if (unit_done) begin
              cur_addr  <= cur_addr + 16'd1;
              remaining <= remaining - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_ram_loader.sv
module tb_sprite_ram_loader;

  localparam int IMG_DEPTH = 4096;
  localparam int PAL_DEPTH = 256;
  localparam int TMO       = 16;

  localparam int K_IMG = 0, K_PAL = 1, K_DONE = 2, K_ERR = 3;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        img_we;
  logic [11:0] img_addr;
  logic [7:0]  img_data;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_data;
  logic        busy;
  logic        done;
  logic        error;

  sprite_ram_loader #(
    .IMG_DEPTH(IMG_DEPTH), .PAL_DEPTH(PAL_DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pixel_clk_in(clk), .rst_in(rst), .byte_in(byte_in), .byte_valid_in(byte_valid),
    .img_we_out(img_we), .img_addr_out(img_addr), .img_data_out(img_data),
    .pal_we_out(pal_we), .pal_addr_out(pal_addr), .pal_data_out(pal_data),
    .busy_out(busy), .done_out(done), .error_out(error)
  );

  typedef struct {
    int kind;
    int addr;
    int data;
    bit wr;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  img_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic string kname(input int k);
    case (k)
      K_IMG:   return "img_write";
      K_PAL:   return "pal_write";
      K_DONE:  return "done";
      default: return "error";
    endcase
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int data, input bit wr);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.wr = wr;
    exp_q.push_back(e);
  endtask

  // Packet-level reference: walks the byte list and predicts the event
  // sequence. A list that runs out before the packet is complete ends in a
  // timeout error unless no_err is set (used when reset cuts the packet).
  task automatic model(input logic [7:0] q[$], input bit no_err);
    int i, ty, addr, n, depth, bpe, d;
    i = 0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    if (i >= q.size()) return;
    i++;
    if (i >= q.size()) begin if (!no_err) push_ev(K_ERR, 0, 0, 0); return; end
    ty = q[i]; i++;
    if (ty != 1 && ty != 2) begin push_ev(K_ERR, 0, 0, 0); return; end
    if (q.size() - i < 2) begin if (!no_err) push_ev(K_ERR, 0, 0, 0); return; end
    addr = q[i] * 256 + q[i+1]; i += 2;
    depth = (ty == 1) ? PAL_DEPTH : IMG_DEPTH;
    if (addr >= depth) begin push_ev(K_ERR, 0, 0, 0); return; end
    if (q.size() - i < 2) begin if (!no_err) push_ev(K_ERR, 0, 0, 0); return; end
    n = q[i] * 256 + q[i+1]; i += 2;
    if (n == 0) begin push_ev(K_DONE, 0, 0, 0); return; end
    bpe = (ty == 1) ? 3 : 1;
    for (int e = 0; e < n; e++) begin
      if (q.size() - i < bpe) begin if (!no_err) push_ev(K_ERR, 0, 0, 0); return; end
      d = (ty == 1) ? (q[i] * 65536 + q[i+1] * 256 + q[i+2]) : q[i];
      push_ev((ty == 1) ? K_PAL : K_IMG, (addr + e) % depth, d, 0);
      i += bpe;
      if (e == n - 1) push_ev(K_DONE, 0, 0, 1);
    end
  endtask

  task automatic pop_check(input int kind, input int addr, input int data, input bit wr);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got addr %0h data %0h, expected no event", kname(kind), addr, data);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        if (kind == K_IMG || kind == K_PAL) begin
          chk({kname(kind), "_addr"}, addr, e.addr);
          chk({kname(kind), "_data"}, data, e.data);
        end
        if (kind == K_DONE) chk("done_with_final_write", wr, e.wr);
      end
    end
  endtask

  // Monitor: samples on the falling edge, pops and compares each event.
  always @(negedge clk) begin
    if (img_we || pal_we) chk("we_exclusive", img_we && pal_we, 0);
    if (done || error)    chk("done_error_exclusive", done && error, 0);
    if (img_we) begin
      img_cyc.push_back(cyc);
      pop_check(K_IMG, img_addr, img_data, 0);
    end
    if (pal_we) pop_check(K_PAL, pal_addr, pal_data, 0);
    if (done) begin
      pop_check(K_DONE, 0, 0, img_we || pal_we);
      chk("busy_low_at_done", busy, 0);
    end
    if (error) pop_check(K_ERR, 0, 0, 0);
  end

  // Called at a falling edge; returns at the falling edge after the byte's
  // capturing rising edge, with byte_valid deasserted.
  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] q[$], input int maxgap);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i != q.size() - 1 && maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_within_budget", (exp_q.size() != 0) || busy, 0);
    exp_q.delete();
  endtask

  task automatic run(input logic [7:0] q[$], input int maxgap);
    model(q, 0);
    send_pkt(q, maxgap);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] b;
    int c, ty, depth, addr, n, bpe, ng;

    rst        = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_img_we", img_we, 0);
    chk("reset_pal_we", pal_we, 0);
    chk("reset_outputs_other", {img_addr, img_data, pal_addr, pal_data, busy, done, error}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Image load, back-to-back
    q = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    model(q, 0);
    img_cyc.delete();
    send_pkt(q, 0);
    chk("img_latency_we", img_we, 1);
    chk("img_latency_done", done, 1);
    drain();
    chk("img_strobe_count", img_cyc.size(), 3);
    if (img_cyc.size() == 3) chk("img_back_to_back", img_cyc[2] - img_cyc[0], 2);

    // Palette load with gaps; strobe must appear one cycle after each B byte
    q = '{8'hA5, 8'h01, 8'h00, 8'hFE, 8'h00, 8'h02, 8'h92, 8'h90, 8'hFF, 8'h00, 8'h00, 8'h00};
    model(q, 0);
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      if (i == 8 || i == 11) chk("pal_latency_we", pal_we, 1);
      repeat (2) @(negedge clk);
    end
    drain();

    // Image wrap at the top of the RAM
    run('{8'hA5, 8'h02, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h5C, 8'hC5}, 0);

    // Bad type, out-of-range addresses, empty packet, leading garbage
    run('{8'hA5, 8'h07}, 0);
    run('{8'hA5, 8'h02, 8'h10, 8'h00}, 0);
    run('{8'hA5, 8'h01, 8'h01, 8'h00}, 0);
    run('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    q = '{8'h00, 8'h5A, 8'hFF};
    send_pkt(q, 0);
    chk("garbage_not_busy", busy, 0);
    run('{8'hA5, 8'h02, 8'h03, 8'h00, 8'h00, 8'h01, 8'h77}, 1);

    // Timeout after one payload byte of four
    q = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h00, 8'h04, 8'h5A};
    model(q, 0);
    send_pkt(q, 0);
    c = 0;
    while (!error && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_idle_cycles", c, TMO);
    drain();
    run('{8'hA5, 8'h01, 8'h00, 8'h07, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03}, 0);

    // Reset mid-payload: writes already issued stand, no error pulse
    q = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h04, 8'hC1, 8'hC2};
    model(q, 1);
    send_pkt(q, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_img_we", img_we, 0);
    chk("midrst_outputs_other", {img_addr, img_data, pal_addr, pal_data, pal_we, busy, done, error}, 0);
    chk("midrst_events_consumed", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    run('{8'hA5, 8'h02, 8'h02, 8'h00, 8'h00, 8'h02, 8'hD1, 8'hD2}, 0);

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      q.delete();
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        q.push_back(b);
      end
      c = $urandom_range(0, 9);
      ty = (c == 0) ? 7 : ((c < 5) ? 1 : 2);
      depth = (ty == 1) ? PAL_DEPTH : IMG_DEPTH;
      addr = ($urandom_range(0, 9) == 0) ? depth + $urandom_range(0, 3)
                                         : $urandom_range(depth - 3, depth - 1) - (($urandom_range(0, 1) == 1) ? $urandom_range(0, depth - 4) : 0);
      n = $urandom_range(0, 5);
      bpe = (ty == 1) ? 3 : 1;
      q.push_back(8'hA5);
      q.push_back(8'(ty));
      q.push_back(8'(addr >> 8));
      q.push_back(8'(addr));
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      for (int k = 0; k < n * bpe; k++) q.push_back(8'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        c = $urandom_range(ng + 1, q.size() - 1);
        while (q.size() > c) void'(q.pop_back());
      end
      run(q, 3);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_ram_loader.md
Name: sprite_ram_loader

Overview:
Writer side of the sprite image/palette RAM pair. Parses a byte stream (e.g. from the UART receiver) carrying load packets and emits write strobes for the 8-bit image-index RAM and the 24-bit palette RAM. The sprite renderer reads these RAMs on its read-only port. Lets us swap Mario animation frames and palettes at runtime without rebuilding the bitstream.

Parameters:
IMG_DEPTH, 4096, image RAM entries (power of two); image address width = $clog2(IMG_DEPTH)
PAL_DEPTH, 256, palette RAM entries (power of two); palette address width = $clog2(PAL_DEPTH)
TIMEOUT_CYCLES, 1000000, max idle cycles between bytes inside a packet before abort

Ports:
pixel_clk_in  input  1  clock; all logic is on its rising edge
rst_in  input  1  synchronous, active-high reset
byte_in  input  8  stream byte
byte_valid_in  input  1  byte_in is valid this cycle; one byte is consumed per valid cycle, no backpressure
img_we_out  output  1  image RAM write strobe, one cycle per entry
img_addr_out  output  $clog2(IMG_DEPTH)  image RAM write address
img_data_out  output  8  image RAM write data (palette index)
pal_we_out  output  1  palette RAM write strobe, one cycle per entry
pal_addr_out  output  $clog2(PAL_DEPTH)  palette RAM write address
pal_data_out  output  24  palette write data {R,G,B}
busy_out  output  1  high while in any state other than IDLE
done_out  output  1  one-cycle pulse: packet completed
error_out  output  1  one-cycle pulse: packet aborted

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters cleared. Reset mid-packet aborts without error_out; partial writes already issued stay in RAM.
- Packet: 0xA5 sync, TYPE (0x01 palette, 0x02 image), ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then payload. Palette payload is 3*N bytes (R, G, B per entry). Image payload is N bytes. Fields are big-endian.
- States: IDLE -> TYPE -> ADDR_HI -> ADDR_LO -> CNT_HI -> CNT_LO -> PAYLOAD -> IDLE. Transitions happen only on valid bytes, except timeout.
- IDLE: non-0xA5 bytes are ignored silently.
- TYPE: any value other than 0x01 or 0x02 -> error_out pulse next cycle, return to IDLE.
- ADDR_LO: if the 16-bit start address >= depth of the selected RAM -> error_out, return to IDLE.
- CNT_LO: N = 0 -> done_out pulse next cycle, return to IDLE, no writes. N is 16-bit, 1..65535.
- PAYLOAD, image: each valid byte produces, on the next cycle, img_we_out=1, img_data_out=byte, img_addr_out=current address. Address then increments modulo IMG_DEPTH; wrap is legal and not an error.
- PAYLOAD, palette: R, G and B are latched into a 24-bit shift register. On the cycle after B is received, pal_we_out=1 and pal_data_out={R,G,B}. Address increments modulo PAL_DEPTH.
- Write latency is exactly 1 cycle after the completing byte. Back-to-back valid bytes give back-to-back image strobes.
- addr/data outputs hold their last values while we=0. img_we_out and pal_we_out are never high in the same cycle.
- done_out is asserted in the same cycle as the final write strobe. busy_out drops in that same cycle.
- Timeout: a counter resets on each valid byte while busy. Reaching TIMEOUT_CYCLES-1 idle cycles in any non-IDLE state -> error_out, return to IDLE. Entries already written are not rolled back; a partial palette triple is discarded.
- done_out and error_out are mutually exclusive.

Test Plan:
- Reset: assert rst_in mid-payload -> all outputs 0 next cycle; a following valid packet loads correctly.
- Image load: A5 02 00 10 00 03 11 22 33, back-to-back -> img_we high 3 consecutive cycles at addr 0x010/0x011/0x012 with data 11/22/33; done_out on the third strobe.
- Palette load with gaps: A5 01 00 FE 00 02 92 90 FF 00 00 00, idle cycles between bytes -> pal writes {addr FE, 0x9290FF} and {FF, 0x000000}, each 1 cycle after its B byte.
- Wrap: image start 0x0FFF, N=2 -> writes at 0xFFF then 0x000, no error.
- Errors: TYPE=0x07 -> error_out, no writes; image ADDR=0x1000 -> error_out; N=0 -> done_out, no writes; garbage bytes before A5 are ignored.
- Timeout (TIMEOUT_CYCLES=16): stop after 1 payload byte of N=4 -> one write, then error_out after 16 idle cycles; the next packet is accepted.
